// File: rtl/shift_left_2_unit.sv
// shift_left_2_unit: word-index to byte-offset scaler (x4 by default).
// The combinational result serves single-cycle datapaths. A one-deep registered
// stage with valid/ready handshake reports per-result and sticky overflow.
module shift_left_2_unit #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] out,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             ovf_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  // Left shift with zero fill; the upper SHIFT bits fall off the top.
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
  endfunction

  // Overflow means any of the bits that the shift discards was nonzero.
  function automatic logic f_ovf(input logic [WIDTH-1:0] v);
    return |v[WIDTH-1:WIDTH-SHIFT];
  endfunction

  logic             ovf_s;
  logic             accept_s;
  logic [WIDTH-1:0] out_d;
  logic             ovf_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             ovf_sticky_q;
  logic             ovf_sticky_d;

  // Combinational shift and overflow. This path does not depend on clk or rst_n.
  always_comb begin
    out   = f_shift(inp);
    ovf_s = f_ovf(inp);
  end

  // Handshake. The stage is ready when empty or when being drained this cycle.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept_s = in_valid && in_ready;
  end

  // Next-state logic for the result register and the sticky overflow flag.
  always_comb begin
    out_d        = out_q;
    ovf_d        = ovf_q;
    out_valid_d  = out_valid_q;
    ovf_sticky_d = ovf_sticky_q;
    if (accept_s) begin
      // Covers simultaneous drain and refill: new result replaces old.
      out_d       = out;
      ovf_d       = ovf_s;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      // Drain with no refill. The data is held and only valid drops.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    // Set has priority over clear so an overflow is never lost.
    if (accept_s && ovf_s) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end else begin
      ovf_sticky_d = ovf_sticky_q;
    end
  end

  // State registers. Asynchronous reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= {WIDTH{1'b0}};
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  // Drive the output ports from the registered state.
  always_comb begin
    out_valid  = out_valid_q;
    ovf_sticky = ovf_sticky_q;
  end

endmodule

// File: tb/tb_shift_left_2_unit.sv
// Directed self-checking bench for shift_left_2_unit (WIDTH=32, SHIFT=2).
module tb_shift_left_2_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] inp;
  logic [31:0] out;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_q;
  logic        ovf_q;
  logic        out_valid;
  logic        out_ready;
  logic        ovf_sticky;
  logic        ovf_clr;

  int tests;
  int fails;

  logic [31:0] vec_in  [6];
  logic [31:0] vec_out [6];
  logic        vec_ovf [6];

  shift_left_2_unit #(.WIDTH(32), .SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .out(out),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_q(out_q), .ovf_q(ovf_q), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vec_in[0] = 32'h0000_0000; vec_out[0] = 32'h0000_0000; vec_ovf[0] = 1'b0;
    vec_in[1] = 32'h0000_0001; vec_out[1] = 32'h0000_0004; vec_ovf[1] = 1'b0;
    vec_in[2] = 32'h0000_000A; vec_out[2] = 32'h0000_0028; vec_ovf[2] = 1'b0;
    vec_in[3] = 32'h4000_0000; vec_out[3] = 32'h0000_0000; vec_ovf[3] = 1'b1;
    vec_in[4] = 32'h8000_0000; vec_out[4] = 32'h0000_0000; vec_ovf[4] = 1'b1;
    vec_in[5] = 32'hFFFF_FFFF; vec_out[5] = 32'hFFFF_FFFC; vec_ovf[5] = 1'b1;

    rst_n     = 1'b0;
    inp       = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Combinational path while in reset
    for (int i = 0; i < 6; i++) begin
      inp = vec_in[i];
      #10;
      check($sformatf("comb_rst[%0d]", i), out, vec_out[i]);
    end

    // Reset state
    check("rst_out_q", out_q, 32'h0);
    check("rst_ovf_q", {31'd0, ovf_q}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational path out of reset
    for (int i = 0; i < 6; i++) begin
      inp = vec_in[i];
      #10;
      check($sformatf("comb[%0d]", i), out, vec_out[i]);
    end

    // Back-to-back stream at full throughput
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inp       = vec_in[0];
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("stream_out_q[%0d]", i), out_q, vec_out[i]);
      check($sformatf("stream_ovf_q[%0d]", i), {31'd0, ovf_q}, {31'd0, vec_ovf[i]});
      check($sformatf("stream_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("stream_in_ready[%0d]", i), {31'd0, in_ready}, 32'd1);
      if (i < 5) inp = vec_in[i+1];
      else in_valid = 1'b0;
    end
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_hold_out_q", out_q, 32'hFFFF_FFFC);
    check("stream_sticky", {31'd0, ovf_sticky}, 32'd1);

    // Clear the sticky flag left by the stream
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("pre_clr_sticky", {31'd0, ovf_sticky}, 32'd0);

    // Backpressure
    in_valid  = 1'b1;
    inp       = 32'h0000_0001;
    out_ready = 1'b0;
    step();
    check("bp_first_out_q", out_q, 32'h0000_0004);
    check("bp_first_valid", {31'd0, out_valid}, 32'd1);
    inp = 32'h0000_000A;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_in_ready[%0d]", i), {31'd0, in_ready}, 32'd0);
      step();
      check($sformatf("bp_hold_out_q[%0d]", i), out_q, 32'h0000_0004);
      check($sformatf("bp_hold_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_release_out_q", out_q, 32'h0000_0028);
    in_valid = 1'b0;
    step();
    check("bp_drain_valid", {31'd0, out_valid}, 32'd0);

    // Sticky overflow set, clear and set-over-clear
    in_valid = 1'b1;
    inp      = 32'h8000_0000;
    step();
    check("sticky_set", {31'd0, ovf_sticky}, 32'd1);
    check("sticky_ovf_q", {31'd0, ovf_q}, 32'd1);
    check("sticky_out_q", out_q, 32'h0);
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    step();
    check("sticky_clr", {31'd0, ovf_sticky}, 32'd0);
    in_valid = 1'b1;
    inp      = 32'hFFFF_FFFF;
    step();
    check("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
    check("sticky_ff_out_q", out_q, 32'hFFFF_FFFC);
    ovf_clr   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_out_q", out_q, 32'hFFFF_FFFC);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_q", out_q, 32'h0);
    check("midrst_ovf_q", {31'd0, ovf_q}, 32'd0);
    check("midrst_sticky", {31'd0, ovf_sticky}, 32'd0);
    #2;
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    inp       = 32'h0000_000A;
    step();
    check("postrst_out_q", out_q, 32'h0000_0028);
    check("postrst_ovf_q", {31'd0, ovf_q}, 32'd0);
    check("postrst_valid", {31'd0, out_valid}, 32'd1);
    inp = 32'h4000_0000;
    step();
    check("postrst2_out_q", out_q, 32'h0);
    check("postrst2_ovf_q", {31'd0, ovf_q}, 32'd1);
    in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
